score_scan_ctrl: RTL and testbench
==================================

SCORE_SCAN_CTRL -- requirements
Module: score_scan_ctrl

Interface
REQ-001 Parameter SCAN_PERIOD, default 200000, clock cycles each 7-seg tube stays selected.
REQ-002 Parameter BLINK_HALF, default 50000000, clock cycles per on or off phase of the DONE blink.
REQ-003 clk  in  1  system clock (100 MHz); all logic SHALL be on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse, begin a challenge round.
REQ-006 finish  in  1  one-cycle pulse, round over.
REQ-007 clear  in  1  one-cycle pulse, abort and zero the score.
REQ-008 hit  in  1  one-cycle pulse, correct note played.
REQ-009 miss  in  1  one-cycle pulse, wrong or late note.
REQ-010 difficulty  in  3  one-hot: 100 EASY, 010 NORMAL, 001 HARD.
REQ-011 label  in  32  four segment codes for tubes 7..4, [31:24] on tube 7.
REQ-012 character  in  24  segment codes from the binary-to-decimal converter: [23:16] hundreds, [15:8] tens, [7:0] ones.
REQ-013 scores  out  10  registered score, wired to the converter input.
REQ-014 seg_en  out  8  one-hot tube select, active-high, bit n = tube n.
REQ-015 seg_out  out  8  segment code for the selected tube.
REQ-016 busy  out  1  high in RUN.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 The FSM SHALL make these transitions: IDLE->RUN on start; RUN->DONE on finish; any state->IDLE on clear; start in RUN or DONE is ignored; finish outside RUN is ignored.
REQ-019 clear SHALL have priority over start, finish, hit and miss in the same cycle, and SHALL set scores to 0.
REQ-020 IDLE->RUN SHALL zero scores and latch difficulty; later difficulty changes SHALL have no effect until the next start.
REQ-021 Points per hit SHALL be: EASY 1, NORMAL 2, HARD 3; any non-one-hot latched value SHALL give 1.
REQ-022 In RUN, scores SHALL update one cycle after hit/miss as: score + (hit ? pts : 0) - (miss ? 1 : 0), with the result clamped to 0..255. The converter only decodes 8 bits, so 255 is the ceiling and scores[9:8] are always 0.
REQ-023 hit and miss outside RUN SHALL be ignored; hit and miss together SHALL apply the net value (e.g. HARD gives +2).
REQ-024 If finish and hit arrive in the same cycle, the hit SHALL be counted and the state SHALL go to DONE; the score then stays frozen in DONE.
REQ-025 The scan counter SHALL count 0..SCAN_PERIOD-1; at wrap the tube index SHALL advance n->n+1, and 7 SHALL wrap to 0.
REQ-026 seg_out SHALL be combinational from the tube index: tubes 7..4 show label bytes, tube 3 shows 8'h00, tubes 2..0 show character[23:16], [15:8] and [7:0].
REQ-027 In DONE, a blink counter SHALL toggle a phase every BLINK_HALF cycles, starting in the on phase; in the off phase seg_out SHALL be 8'h00 while seg_en keeps scanning.
REQ-028 In IDLE and RUN, the blink phase SHALL be held at on.

Reset
REQ-029 While rst is high, the block SHALL set: state IDLE, scores 0, latched difficulty EASY, scan counter 0, tube index 0, blink counter 0, phase on.
REQ-030 Post-reset outputs SHALL be: seg_en 8'b00000001, seg_out = character[7:0] (8'b11111100 for score 0), busy 0.
REQ-031 rst asserted mid-round SHALL abort immediately, with no score retained.

Configuration
REQ-032 The macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-033 When LEADING_ZERO_BLANK_EN is defined: tube 2 shows 8'h00 when scores < 100, and tube 1 shows 8'h00 when scores < 10; tube 0 is never blanked.
REQ-034 When LEADING_ZERO_BLANK_EN is undefined, all three score digits SHALL always be displayed.

Verification (bench overrides SCAN_PERIOD=4, BLINK_HALF=16)
REQ-035 Reset release: seg_en 01 then 02 after 4 cycles, and back to 01 after 32 cycles; seg_out on tube 0 = 11111100.
REQ-036 Scoring: start with HARD, 5 hits, 1 miss, then 1 cycle of hit+miss -> scores 16; hit before start -> ignored.
REQ-037 Saturation: EASY, 300 hits -> scores 255; then miss -> 254. Floor: a fresh round with miss -> scores 0.
REQ-038 Same-cycle events: finish+hit on NORMAL at score 10 -> scores 12 and state DONE; a later hit -> still 12.
REQ-039 DONE blink: seg_out is the digit for 16 cycles and 00 for 16 cycles while seg_en continues scanning; clear -> IDLE, scores 0, output steady.
REQ-040 Macro check at scores 7, tubes 2/1/0: with LEADING_ZERO_BLANK_EN -> 00/00/11100000; without it -> 11111100/11111100/11100000.

Source files
------------

// File: rtl/score_scan_ctrl_if.sv
// rtl/score_scan_ctrl_if.sv - game-control and 7-seg display bundle for score_scan_ctrl
interface score_scan_ctrl_if;
    logic        start;
    logic        finish;
    logic        clear;
    logic        hit;
    logic        miss;
    logic [2:0]  difficulty;
    logic [31:0] label;
    logic [23:0] character;
    logic [9:0]  scores;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic        busy;

    modport master (
        output start, finish, clear, hit, miss, difficulty, label, character,
        input  scores, seg_en, seg_out, busy
    );

    modport slave (
        input  start, finish, clear, hit, miss, difficulty, label, character,
        output scores, seg_en, seg_out, busy
    );
endinterface

// File: rtl/score_scan_ctrl.sv
// rtl/score_scan_ctrl.sv - round FSM, saturating score and 8-tube 7-seg scanner with DONE blink
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros of the hundreds and tens digits.
module score_scan_ctrl #(
    parameter int SCAN_PERIOD = 200000,
    parameter int BLINK_HALF  = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    score_scan_ctrl_if.slave   bus
);
    localparam int SW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int BW = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [7:0]      score, score_nxt, score_adj;
    logic [2:0]      diff_q;
    logic [1:0]      pts;
    logic [9:0]      up, dn;
    logic [SW-1:0]   scan_cnt;
    logic [2:0]      tube;
    logic [BW-1:0]   blink_cnt;
    logic            phase_on;
    logic [7:0]      digit;

    // Net hit/miss adjustment, clamped to what the 8-bit converter can show
    always_comb begin
        case (diff_q)
            3'b100:  pts = 2'd1;
            3'b010:  pts = 2'd2;
            3'b001:  pts = 2'd3;
            default: pts = 2'd1;
        endcase
        up = {2'b00, score} + {8'b0, (bus.hit ? pts : 2'd0)};
        dn = up - {9'b0, bus.miss};
        if (bus.miss && up == 10'd0)
            score_adj = 8'd0;
        else if (dn > 10'd255)
            score_adj = 8'd255;
        else
            score_adj = dn[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            score <= 8'd0;
        end else begin
            state <= state_nxt;
            score <= score_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        score_nxt = score;
        if (bus.clear) begin
            state_nxt = IDLE;
            score_nxt = 8'd0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state_nxt = RUN;
                    score_nxt = 8'd0;
                end
                RUN: begin
                    if (bus.hit || bus.miss) score_nxt = score_adj;
                    if (bus.finish)          state_nxt = DONE;
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            diff_q <= 3'b100;
        else if (!bus.clear && state == IDLE && bus.start)
            diff_q <= bus.difficulty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            tube     <= 3'd0;
        end else if (scan_cnt == SW'(SCAN_PERIOD - 1)) begin
            scan_cnt <= '0;
            tube     <= tube + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Blink counter idles in the on phase until DONE has actually been entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (state_nxt != DONE) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (state == DONE) begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                phase_on  <= ~phase_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        digit = 8'h00;
        case (tube)
            3'd7: digit = bus.label[31:24];
            3'd6: digit = bus.label[23:16];
            3'd5: digit = bus.label[15:8];
            3'd4: digit = bus.label[7:0];
            3'd3: digit = 8'h00;
            3'd2: digit = bus.character[23:16];
            3'd1: digit = bus.character[15:8];
            3'd0: digit = bus.character[7:0];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (tube == 3'd2 && score < 8'd100) digit = 8'h00;
        if (tube == 3'd1 && score < 8'd10)  digit = 8'h00;
`else
`endif
        bus.seg_out = phase_on ? digit : 8'h00;
    end

    assign bus.seg_en = 8'h01 << tube;
    assign bus.scores = {2'b00, score};
    assign bus.busy   = (state == RUN);
endmodule

// File: tb/tb_score_scan_ctrl.sv
// tb/tb_score_scan_ctrl.sv - directed and randomized bench for score_scan_ctrl with behavioural model
module tb_score_scan_ctrl;
    localparam int SP = 4;
    localparam int BH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    score_scan_ctrl_if bus();

    score_scan_ctrl #(.SCAN_PERIOD(SP), .BLINK_HALF(BH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit run_cmp   = 1'b0;

    // Model: state 0 idle, 1 run, 2 done; cycle counts since reset and since entering done
    int       m_state, m_score, m_cyc, m_done;
    logic [2:0] m_diff;

    function automatic logic [7:0] enc(input int d);
        case (d)
            0: enc = 8'hFC; 1: enc = 8'h60; 2: enc = 8'hDA; 3: enc = 8'hF2;
            4: enc = 8'h66; 5: enc = 8'hB6; 6: enc = 8'hBE; 7: enc = 8'hE0;
            8: enc = 8'hFE; default: enc = 8'hF6;
        endcase
    endfunction

    function automatic int points(input logic [2:0] d);
        if (d == 3'b010) return 2;
        if (d == 3'b001) return 3;
        return 1;
    endfunction

    assign bus.character = {enc(m_score / 100), enc((m_score / 10) % 10), enc(m_score % 10)};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_score = 0; m_cyc = 0; m_done = 0; m_diff = 3'b100;
        end else begin
            m_cyc++;
            if (bus.clear) begin
                m_state = 0; m_score = 0;
            end else if (m_state == 0) begin
                if (bus.start) begin m_state = 1; m_score = 0; m_diff = bus.difficulty; end
            end else if (m_state == 1) begin
                if (bus.hit || bus.miss) begin
                    m_score = m_score + (bus.hit ? points(m_diff) : 0) - (bus.miss ? 1 : 0);
                    if (m_score < 0)   m_score = 0;
                    if (m_score > 255) m_score = 255;
                end
                if (bus.finish) begin m_state = 2; m_done = 0; end
            end else begin
                m_done++;
            end
        end
    end

    function automatic logic [7:0] exp_seg_out();
        int t;
        logic [7:0] d;
        t = (m_cyc / SP) % 8;
        case (t)
            7: d = bus.label[31:24]; 6: d = bus.label[23:16];
            5: d = bus.label[15:8];  4: d = bus.label[7:0];
            3: d = 8'h00;            2: d = bus.character[23:16];
            1: d = bus.character[15:8]; default: d = bus.character[7:0];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (t == 2 && m_score < 100) d = 8'h00;
        if (t == 1 && m_score < 10)  d = 8'h00;
`else
`endif
        if (m_state == 2 && ((m_done / BH) % 2) == 1) d = 8'h00;
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && run_cmp) begin
            chk("m_scores",  {22'b0, bus.scores}, m_score);
            chk("m_busy",    {31'b0, bus.busy}, (m_state == 1) ? 1 : 0);
            chk("m_seg_en",  {24'b0, bus.seg_en}, 32'h1 << ((m_cyc / SP) % 8));
            chk("m_seg_out", {24'b0, bus.seg_out}, {24'b0, exp_seg_out()});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input bit s, input bit f, input bit c, input bit h, input bit m);
        bus.start = s; bus.finish = f; bus.clear = c; bus.hit = h; bus.miss = m;
        cyc(1);
        bus.start = 0; bus.finish = 0; bus.clear = 0; bus.hit = 0; bus.miss = 0;
    endtask

    task automatic seek_tube(input int t, output bit found);
        logic [7:0] want;
        want = 8'h01 << t;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.seg_en == want) begin found = 1'b1; break; end
            cyc(1);
        end
    endtask

    initial begin
        bit found;
        int on_nz, off_nz, en_chg;
        logic [7:0] prev_en, e2, e1;
        bus.start = 0; bus.finish = 0; bus.clear = 0; bus.hit = 0; bus.miss = 0;
        bus.difficulty = 3'b100;
        bus.label = 32'hB69EFE60;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_seg_en",  bus.seg_en, 8'h01);
        chk("rst_seg_out", bus.seg_out, 8'hFC);
        chk("rst_busy",    bus.busy, 0);
        chk("rst_scores",  bus.scores, 0);
        run_cmp = 1'b1;
        cyc(4);
        chk("scan_tube1", bus.seg_en, 8'h02);
        cyc(28);
        chk("scan_wrap", bus.seg_en, 8'h01);

        pulse(0, 0, 0, 1, 0);
        chk("hit_idle", bus.scores, 0);

        bus.difficulty = 3'b001;
        pulse(1, 0, 0, 0, 0);
        bus.difficulty = 3'b100;
        chk("busy_run", bus.busy, 1);
        repeat (5) pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 0, 1);
        pulse(0, 0, 0, 1, 1);
        chk("hard_score", bus.scores, 16);
        pulse(1, 0, 0, 0, 0);
        chk("start_in_run", bus.scores, 16);

        pulse(0, 0, 1, 0, 0);
        pulse(1, 0, 0, 0, 0);
        repeat (7) pulse(0, 0, 0, 1, 0);
        chk("easy_7", bus.scores, 7);
`ifdef LEADING_ZERO_BLANK_EN
        e2 = 8'h00; e1 = 8'h00;
`else
        e2 = 8'hFC; e1 = 8'hFC;
`endif
        seek_tube(2, found); chk("seek2", found, 1); chk("tube2_7", bus.seg_out, e2);
        seek_tube(1, found); chk("seek1", found, 1); chk("tube1_7", bus.seg_out, e1);
        seek_tube(0, found); chk("seek0", found, 1); chk("tube0_7", bus.seg_out, 8'hE0);

        pulse(0, 0, 1, 0, 0);
        pulse(1, 0, 0, 0, 0);
        bus.hit = 1; cyc(300); bus.hit = 0;
        chk("sat_255", bus.scores, 255);
        pulse(0, 0, 0, 0, 1);
        chk("sat_254", bus.scores, 254);

        pulse(0, 0, 1, 0, 0);
        pulse(1, 0, 0, 0, 0);
        pulse(0, 0, 0, 0, 1);
        chk("floor_0", bus.scores, 0);

        pulse(0, 0, 1, 0, 0);
        bus.difficulty = 3'b010;
        pulse(1, 0, 0, 0, 0);
        repeat (5) pulse(0, 0, 0, 1, 0);
        chk("normal_10", bus.scores, 10);
        pulse(0, 1, 0, 1, 0);
        chk("fin_hit_12", bus.scores, 12);
        chk("fin_busy", bus.busy, 0);
        pulse(0, 0, 0, 1, 0);
        chk("done_frozen", bus.scores, 12);

        on_nz = 0; off_nz = 0; en_chg = 0; prev_en = bus.seg_en;
        for (int i = 0; i < 15; i++) begin
            if (bus.seg_out != 8'h00) on_nz++;
            cyc(1);
        end
        for (int i = 0; i < 16; i++) begin
            if (bus.seg_out != 8'h00) off_nz++;
            if (bus.seg_en != prev_en) en_chg++;
            prev_en = bus.seg_en;
            cyc(1);
        end
        chk("blink_on",   on_nz >= 11, 1);
        chk("blink_off",  off_nz, 0);
        chk("blink_scan", en_chg >= 3, 1);

        pulse(0, 0, 1, 0, 0);
        chk("clr_scores", bus.scores, 0);
        chk("clr_busy",   bus.busy, 0);
        off_nz = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus.seg_out == 8'h00 && bus.seg_en != 8'h08) off_nz++;
            cyc(1);
        end
        chk("clr_steady", off_nz, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst = 1'b1;
                cyc(2);
                rst = 1'b0;
            end
            bus.start  = ($urandom_range(0, 19) == 0);
            bus.finish = ($urandom_range(0, 59) == 0);
            bus.clear  = ($urandom_range(0, 299) == 0);
            bus.hit    = ($urandom_range(0, 2) == 0);
            bus.miss   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) bus.difficulty = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) bus.label = $urandom;
            cyc(1);
        end
        bus.start = 0; bus.finish = 0; bus.clear = 0; bus.hit = 0; bus.miss = 0;
        cyc(2);
        run_cmp = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
